// File: rtl/wedrain_pkg.sv
// Shared types for the ping-pong ADC drain: FSM encoding, default tags and the
// header/trailer marker word layout.
package wedrain_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StRead,
    StTrailer,
    StWaitClr,
    StFlush
  } state_e;

  localparam logic [15:0] HdrTagDef = 16'hA5A5;
  localparam logic [15:0] TrlTagDef = 16'h5A5A;

  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] seq;
  } marker_t;

  // One entry of the output buffer: stream word plus its last flag.
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  function automatic logic [31:0] make_marker(input logic [15:0] tag, input logic [15:0] seq);
    marker_t m;
    m.tag = tag;
    m.seq = seq;
    return m;
  endfunction

endpackage

// File: rtl/adc_pp_drain_if.sv
// Output word stream of the ADC drain (data, valid, last, ready).
interface adc_pp_drain_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;

  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/stream_buf2.sv
// Two-entry valid/ready FIFO; the head entry is held stable until it is taken.
module stream_buf2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/adc_pp_drain.sv
// Drains one ping-pong FIFO bank per frame into a framed word stream
// (header, BANK_DEPTH data words, trailer), with flush/force-flip support.
module adc_pp_drain
  import wedrain_pkg::*;
#(
  parameter int unsigned BANK_DEPTH    = 512,
  parameter logic [15:0] HDR_TAG       = HdrTagDef,
  parameter logic [15:0] TRL_TAG       = TrlTagDef,
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input  logic                  clk_100m,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  full_ppfifo,
  input  logic [31:0]           data_out_adc,
  input  logic                  flush,
  output logic                  adc_out_rd,
  output logic                  force_flip,
  adc_pp_drain_if.master        m_if,
  output logic                  busy,
  output logic [15:0]           frame_seq,
  output logic                  flush_to
);

  localparam int unsigned RdW = $clog2(BANK_DEPTH + 1);
  localparam int unsigned ToW = $clog2(FLUSH_TIMEOUT + 1);

  state_e         r_state, w_state_d;
  logic           r_full_meta, r_full_s;
  logic           r_pend, r_rd_inflight, r_flush_to;
  logic [RdW-1:0] r_rd_cnt;
  logic [ToW-1:0] r_to_cnt;
  logic [15:0]    r_frame_seq;

  logic           w_buf_valid, w_buf_ready, w_out_valid, w_pop, w_trl_acc;
  logic           w_clr_pend, w_set_to;
  beat_t          w_buf_in, w_buf_out;
  logic [1:0]     w_count, w_occ;

  stream_buf2 #(
    .WIDTH ($bits(beat_t))
  ) u_buf (
    .clk     (clk_100m),
    .rst     (rst),
    .i_valid (w_buf_valid),
    .o_ready (w_buf_ready),
    .i_data  (w_buf_in),
    .o_valid (w_out_valid),
    .i_ready (m_if.m_ready),
    .o_data  (w_buf_out),
    .o_count (w_count)
  );

  assign m_if.m_valid = w_out_valid;
  assign m_if.m_data  = w_buf_out.data;
  assign m_if.m_last  = w_out_valid & w_buf_out.last;
  assign w_pop        = w_out_valid & m_if.m_ready;
  assign w_trl_acc    = w_pop & w_buf_out.last;
  // Occupancy after this cycle's pop, so back-to-back reads sustain 1 word/cycle.
  assign w_occ        = w_count - {1'b0, w_pop};

  assign busy       = (r_state != StIdle);
  assign force_flip = (r_state == StFlush);
  assign frame_seq  = r_frame_seq;
  assign flush_to   = r_flush_to;

  always_comb begin
    w_state_d   = r_state;
    w_buf_valid = 1'b0;
    w_buf_in    = '0;
    adc_out_rd  = 1'b0;
    w_clr_pend  = 1'b0;
    w_set_to    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (enable && r_full_s) begin
          w_state_d  = StHeader;
          w_clr_pend = 1'b1;
        end else if (r_pend || flush) begin
          w_state_d  = StFlush;
          w_clr_pend = 1'b1;
        end
      end
      StHeader: begin
        w_buf_valid   = 1'b1;
        w_buf_in.data = make_marker(HDR_TAG, r_frame_seq);
        if (w_buf_ready) w_state_d = StRead;
      end
      StRead: begin
        adc_out_rd    = (r_rd_cnt != RdW'(BANK_DEPTH)) &&
                        (({1'b0, w_occ} + {2'b00, r_rd_inflight}) < 3'd2);
        w_buf_valid   = r_rd_inflight;
        w_buf_in.data = data_out_adc;
        if (r_rd_inflight && (r_rd_cnt == RdW'(BANK_DEPTH))) w_state_d = StTrailer;
      end
      StTrailer: begin
        w_buf_valid   = 1'b1;
        w_buf_in.last = 1'b1;
        w_buf_in.data = make_marker(TRL_TAG, r_frame_seq);
        if (w_buf_ready) w_state_d = StWaitClr;
      end
      StWaitClr: begin
        // Also wait for the trailer to drain so the next header carries the new sequence.
        if (!r_full_s && (w_count == 2'd0)) w_state_d = StIdle;
      end
      StFlush: begin
        if (r_full_s) begin
          w_state_d  = StHeader;
          w_clr_pend = 1'b1;
        end else if (r_to_cnt == ToW'(FLUSH_TIMEOUT - 1)) begin
          w_state_d = StIdle;
          w_set_to  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      r_state       <= StIdle;
      r_full_meta   <= 1'b0;
      r_full_s      <= 1'b0;
      r_pend        <= 1'b0;
      r_rd_inflight <= 1'b0;
      r_flush_to    <= 1'b0;
      r_rd_cnt      <= '0;
      r_to_cnt      <= '0;
      r_frame_seq   <= 16'd0;
    end else begin
      r_full_meta   <= full_ppfifo;
      r_full_s      <= r_full_meta;
      r_state       <= w_state_d;
      r_rd_inflight <= adc_out_rd;
      if (r_state != StRead)  r_rd_cnt <= '0;
      else if (adc_out_rd)    r_rd_cnt <= r_rd_cnt + RdW'(1);
      if (r_state != StFlush) r_to_cnt <= '0;
      else                    r_to_cnt <= r_to_cnt + ToW'(1);
      if (w_clr_pend)                      r_pend <= 1'b0;
      else if (flush && r_state != StIdle) r_pend <= 1'b1;
      if (w_set_to)  r_flush_to  <= 1'b1;
      if (w_trl_acc) r_frame_seq <= r_frame_seq + 16'd1;
    end
  end

endmodule

// File: tb/tb_adc_pp_drain.sv
// Directed bench for adc_pp_drain with BANK_DEPTH=4: frame table plus flush,
// hold-high, enable, sequence-wrap and mid-frame reset sequences.
module tb_adc_pp_drain;

  logic        clk_100m = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        full_ppfifo = 1'b0;
  logic [31:0] data_out_adc = '0;
  logic        flush = 1'b0;
  logic        adc_out_rd, force_flip, busy, flush_to;
  logic [15:0] frame_seq;

  adc_pp_drain_if m_if ();

  adc_pp_drain #(
    .BANK_DEPTH    (4),
    .FLUSH_TIMEOUT (1024)
  ) dut (
    .clk_100m     (clk_100m),
    .rst          (rst),
    .enable       (enable),
    .full_ppfifo  (full_ppfifo),
    .data_out_adc (data_out_adc),
    .flush        (flush),
    .adc_out_rd   (adc_out_rd),
    .force_flip   (force_flip),
    .m_if         (m_if),
    .busy         (busy),
    .frame_seq    (frame_seq),
    .flush_to     (flush_to)
  );

  always #5 clk_100m = ~clk_100m;

  int               n_vec = 0;
  int               n_err = 0;
  int               rmode = 0;
  int               cyc = 0;
  int               rd_idx = 0;
  int               rd_cnt = 0;
  int               acc_cnt = 0;
  int               ff_cnt = 0;
  logic             rd_seen = 1'b0;
  logic [0:3][31:0] cur_din = '0;
  logic [32:0]      got_q [$];
  logic [15:0]      exp_seq;

  typedef struct {
    int               rmode;
    logic [0:3][31:0] din;
    logic [0:5][31:0] dout;
    logic [15:0]      seq_after;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100m);
      #1;
    end
  endtask

  // FIFO read-data model and m_ready pattern, driven just after each rising edge.
  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk_100m);
      #1;
      cyc++;
      if (rd_seen) begin
        data_out_adc = cur_din[rd_idx % 4];
        rd_idx++;
      end
      case (rmode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = ~m_if.m_ready;
        default: m_if.m_ready = ((cyc % 4) < 2);
      endcase
    end
  end

  // Output monitor; reads must keep (words in buffer after this pop + in flight) below 2.
  always @(negedge clk_100m) begin
    logic pop;
    int   outstanding;
    pop = m_if.m_valid && m_if.m_ready;
    if (adc_out_rd) begin
      outstanding = 1 + rd_cnt - (acc_cnt + (pop ? 1 : 0));
      check("rd_occupancy", 64'(outstanding < 2), 64'(1));
    end
    if (pop) begin
      got_q.push_back({m_if.m_last, m_if.m_data});
      acc_cnt++;
    end
    if (adc_out_rd) rd_cnt++;
    if (force_flip) ff_cnt++;
    rd_seen = adc_out_rd;
  end

  initial begin
    repeat (50000) @(posedge clk_100m);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_counts();
    got_q.delete();
    rd_cnt  = 0;
    acc_cnt = 0;
    ff_cnt  = 0;
    rd_idx  = 0;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 64'(got_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 64'(busy), 64'(0));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] seq);
    check({tag, "_nwords"}, 64'(got_q.size()), 64'(6));
    if (got_q.size() >= 6) begin
      check({tag, "_hdr"}, 64'(got_q[0]), 64'({1'b0, 16'hA5A5, seq}));
      for (int i = 1; i <= 4; i++)
        check($sformatf("%s_data%0d", tag, i), 64'(got_q[i]), 64'({1'b0, cur_din[i-1]}));
      check({tag, "_trl"}, 64'(got_q[5]), 64'({1'b1, 16'h5A5A, seq}));
    end
  endtask

  initial begin
    vecs[0].rmode     = 0;
    vecs[0].din       = {32'd1, 32'd2, 32'd3, 32'd4};
    vecs[0].dout      = {32'hA5A5_0000, 32'd1, 32'd2, 32'd3, 32'd4, 32'h5A5A_0000};
    vecs[0].seq_after = 16'd1;
    vecs[1].rmode     = 1;
    vecs[1].din       = {32'd1, 32'd2, 32'd3, 32'd4};
    vecs[1].dout      = {32'hA5A5_0001, 32'd1, 32'd2, 32'd3, 32'd4, 32'h5A5A_0001};
    vecs[1].seq_after = 16'd2;
    vecs[2].rmode     = 2;
    vecs[2].din       = {32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h0000_A5A5};
    vecs[2].dout      = {32'hA5A5_0002, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h0000_A5A5,
                         32'h5A5A_0002};
    vecs[2].seq_after = 16'd3;

    // Reset state
    tick(3);
    @(negedge clk_100m);
    check("reset_stream", 64'({m_if.m_valid, m_if.m_last, m_if.m_data}), 64'(0));
    check("reset_ctrl", 64'({adc_out_rd, force_flip, busy}), 64'(0));
    check("reset_status", 64'({frame_seq, flush_to}), 64'(0));
    tick(1);
    rst = 1'b0;
    tick(2);

    // Frame table under different m_ready patterns
    for (int v = 0; v < 3; v++) begin
      rmode   = vecs[v].rmode;
      cur_din = vecs[v].din;
      clear_counts();
      full_ppfifo = 1'b1;
      wait_words(6, 300, $sformatf("vec%0d_words", v));
      full_ppfifo = 1'b0;
      wait_idle(50, $sformatf("vec%0d_idle", v));
      check($sformatf("vec%0d_nwords", v), 64'(got_q.size()), 64'(6));
      if (got_q.size() >= 6)
        for (int i = 0; i < 6; i++)
          check($sformatf("vec%0d_word%0d", v, i), 64'(got_q[i]),
                64'({(i == 5), vecs[v].dout[i]}));
      check($sformatf("vec%0d_rd_pulses", v), 64'(rd_cnt), 64'(4));
      check($sformatf("vec%0d_frame_seq", v), 64'(frame_seq), 64'(vecs[v].seq_after));
    end
    rmode   = 0;
    exp_seq = 16'd3;
    cur_din = {32'h11, 32'h22, 32'h33, 32'h44};

    // full held high after a frame: exactly one frame until it falls and rises again
    clear_counts();
    full_ppfifo = 1'b1;
    wait_words(6, 300, "hold_words");
    tick(50);
    check_frame("hold", exp_seq);
    check("hold_busy", 64'(busy), 64'(1));
    check("hold_rd_pulses", 64'(rd_cnt), 64'(4));
    exp_seq++;
    full_ppfifo = 1'b0;
    wait_idle(50, "hold_idle");
    clear_counts();
    full_ppfifo = 1'b1;
    wait_words(6, 300, "rearm_words");
    full_ppfifo = 1'b0;
    wait_idle(50, "rearm_idle");
    check_frame("rearm", exp_seq);
    exp_seq++;

    // enable=0 blocks new frames but does not abort one in progress
    enable = 1'b0;
    clear_counts();
    full_ppfifo = 1'b1;
    tick(20);
    check("en0_busy", 64'(busy), 64'(0));
    check("en0_words", 64'(got_q.size()), 64'(0));
    enable = 1'b1;
    wait_words(1, 50, "en_hdr");
    enable = 1'b0;
    wait_words(6, 300, "en_words");
    full_ppfifo = 1'b0;
    wait_idle(50, "en_idle");
    check_frame("en_mid", exp_seq);
    exp_seq++;
    enable = 1'b1;

    // flush during a frame is remembered and serviced after WAIT_CLR
    clear_counts();
    full_ppfifo = 1'b1;
    wait_words(2, 100, "pend_start");
    pulse_flush();
    wait_words(6, 300, "pend_words");
    full_ppfifo = 1'b0;
    for (int k = 0; k < 20 && !force_flip; k++) tick(1);
    check("pend_force_flip", 64'(force_flip), 64'(1));
    check_frame("pend_frame1", exp_seq);
    exp_seq++;
    clear_counts();
    full_ppfifo = 1'b1;
    wait_words(6, 300, "pend_flush_words");
    full_ppfifo = 1'b0;
    wait_idle(50, "pend_idle");
    check_frame("pend_frame2", exp_seq);
    exp_seq++;

    // flush in IDLE, bank ready 20 cycles later
    clear_counts();
    pulse_flush();
    tick(19);
    full_ppfifo = 1'b1;
    wait_words(6, 300, "flush_words");
    full_ppfifo = 1'b0;
    wait_idle(50, "flush_idle");
    check("flush_flip_cycles", 64'(ff_cnt >= 20 && ff_cnt <= 24), 64'(1));
    check("flush_to_clear", 64'(flush_to), 64'(0));
    check_frame("flush", exp_seq);
    exp_seq++;

    // flush with no bank ever arriving times out
    clear_counts();
    pulse_flush();
    wait_idle(1100, "timeout_idle");
    check("timeout_flip_cycles", 64'(ff_cnt), 64'(1024));
    check("timeout_flag", 64'(flush_to), 64'(1));
    check("timeout_no_words", 64'(got_q.size()), 64'(0));
    tick(5);
    check("timeout_flag_sticky", 64'(flush_to), 64'(1));

    // frame_seq wrap
    force dut.r_frame_seq = 16'hFFFF;
    tick(1);
    release dut.r_frame_seq;
    clear_counts();
    full_ppfifo = 1'b1;
    wait_words(6, 300, "wrap_words");
    full_ppfifo = 1'b0;
    wait_idle(50, "wrap_idle");
    check_frame("wrap", 16'hFFFF);
    check("wrap_frame_seq", 64'(frame_seq), 64'(0));

    // reset mid-READ abandons the frame
    clear_counts();
    full_ppfifo = 1'b1;
    for (int k = 0; k < 50 && rd_cnt == 0; k++) tick(1);
    check("midrst_reading", 64'(rd_cnt > 0), 64'(1));
    rst         = 1'b1;
    full_ppfifo = 1'b0;
    @(posedge clk_100m);
    @(negedge clk_100m);
    check("midrst_outputs", 64'({adc_out_rd, force_flip, m_if.m_valid, m_if.m_last, busy,
                                 frame_seq, flush_to}), 64'(0));
    check("midrst_m_data", 64'(m_if.m_data), 64'(0));
    tick(1);
    rst = 1'b0;
    got_q.delete();
    tick(20);
    check("midrst_no_trailer", 64'(got_q.size()), 64'(0));
    check("midrst_idle", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_pp_drain.md
ADC_PP_DRAIN -- requirements
Module: adc_pp_drain

Interface
REQ-001 SHALL have parameter BANK_DEPTH, default 512: data words per ping-pong bank drained per frame.
REQ-002 SHALL have parameter HDR_TAG, default 16'hA5A5: header tag in word[31:16].
REQ-003 SHALL have parameter TRL_TAG, default 16'h5A5A: trailer tag in word[31:16].
REQ-004 SHALL have parameter FLUSH_TIMEOUT, default 1024: maximum cycles force_flip is held.
REQ-005 SHALL have these ports:
- clk_100m  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new frames to start.
- full_ppfifo  in  1  bank-ready level from the ping-pong FIFO (asynchronous source).
- data_out_adc  in  32  FIFO read data, valid 1 cycle after adc_out_rd.
- flush  in  1  1-cycle request to drain a partial bank.
- adc_out_rd  out  1  FIFO read enable.
- force_flip  out  1  bank-flip request to the FIFO.
- m_data  out  32  output stream data.
- m_valid  out  1  output stream valid.
- m_last  out  1  marks the trailer word.
- m_ready  in  1  output stream ready.
- busy  out  1  high whenever state != IDLE.
- frame_seq  out  16  sequence number of the next frame.
- flush_to  out  1  sticky flush-timeout flag.

Function
REQ-006 SHALL pass full_ppfifo through a 2-flop synchronizer (full_s); all decisions use full_s.
REQ-007 SHALL implement states IDLE, HEADER, READ, TRAILER, WAIT_CLR, FLUSH.
REQ-008 IDLE SHALL go to HEADER when enable=1 and full_s=1; otherwise it SHALL go to FLUSH when a flush is pending; full_s has priority over a pending flush.
REQ-009 HEADER SHALL enqueue {HDR_TAG, frame_seq} and then go to READ.
REQ-010 READ SHALL assert adc_out_rd for exactly BANK_DEPTH cycles in total, only while (buffer occupancy + reads in flight) < 2.
REQ-011 The word on data_out_adc SHALL be captured into the buffer on the cycle after each adc_out_rd.
REQ-012 READ SHALL go to TRAILER once the last read data has been captured.
REQ-013 TRAILER SHALL enqueue {TRL_TAG, frame_seq} with m_last=1, then go to WAIT_CLR.
REQ-014 frame_seq SHALL increment when the trailer is accepted (m_valid & m_ready), wrapping 16'hFFFF -> 0.
REQ-015 WAIT_CLR SHALL wait for full_s=0, then go to IDLE, so the same bank is never drained twice.
REQ-016 A flush pulse in any state other than IDLE SHALL set a pending latch; the latch SHALL be cleared on entry to FLUSH or HEADER.
REQ-017 FLUSH SHALL hold force_flip=1 until full_s=1 (then go to HEADER, drop force_flip, drain a full BANK_DEPTH frame) or until FLUSH_TIMEOUT cycles elapse (then set flush_to and go to IDLE).
REQ-018 Output SHALL be driven from a 2-entry FIFO buffer: m_valid=1 iff the buffer is non-empty; the head word is held stable until m_ready=1.
REQ-019 Header and trailer SHALL enter the buffer only when it has a free entry; the state machine stalls otherwise; no word SHALL ever be dropped or duplicated.
REQ-020 With m_ready held at 1, throughput SHALL be 1 word per cycle; a frame SHALL take BANK_DEPTH+2 accepted words.
REQ-021 enable=0 SHALL NOT abort a frame in progress; it only blocks the next HEADER.
REQ-022 flush_to SHALL clear only on rst.

Reset
REQ-023 On rst the block SHALL enter IDLE and clear the pending latch, buffer, counters and synchronizer.
REQ-024 On rst all outputs SHALL be 0: adc_out_rd, force_flip, m_valid, m_last, m_data, busy, frame_seq, flush_to.
REQ-025 rst mid-frame SHALL abandon the frame without emitting a trailer.

Structure
REQ-026 SHALL place the state encoding, the default tag values and the header/trailer word layout in a shared package, wedrain_pkg.
REQ-027 SHALL implement the 2-entry output buffer as sub-module stream_buf2 (valid/ready in and out, count output).

Verification
REQ-028 With BANK_DEPTH=4, m_ready=1 and full_ppfifo raised with data 1,2,3,4, the output SHALL be A5A5_0000,1,2,3,4,5A5A_0000 (last on the trailer); frame_seq SHALL become 1; exactly 4 read pulses SHALL occur.
REQ-029 With m_ready toggling 1/0 each cycle, the output SHALL be the same 6 words in order; adc_out_rd SHALL never be asserted while buffer occupancy + in-flight reads = 2.
REQ-030 With full_ppfifo held high for 50 cycles after a frame, exactly one frame SHALL be emitted; a second frame SHALL start only after full_ppfifo falls and rises again.
REQ-031 A flush in IDLE, with full_ppfifo rising 20 cycles later, SHALL hold force_flip high for about 20 cycles (plus synchronizer latency), then emit a 6-word frame; flush_to SHALL stay 0.
REQ-032 A flush with full_ppfifo never rising SHALL produce force_flip high for 1024 cycles, then flush_to=1, busy=0 and no output words.
REQ-033 With frame_seq preloaded to FFFF via 65535 frames (or a forced value), the next header SHALL be A5A5_FFFF and frame_seq SHALL then wrap to 0000; rst asserted mid-READ SHALL return all outputs to 0 on the next cycle.
